// File: rtl/pdm_capture_seq.sv
// Capture sequencer: arms on a ctrl command, deserializes the PDM bit stream
// MSB-first into 32-bit words and strobes each word into the sample buffer.
module pdm_capture_seq #(
  parameter int IDX_W         = 16,
  parameter int CAPTURE_WORDS = 1024
) (
  input  logic             PDMclk,
  input  logic             rst,
  input  logic [1:0]       ctrl,
  input  logic             pdm_signal,
  output logic [31:0]      pdm,
  output logic             RW,
  output logic [IDX_W-1:0] didx,
  output logic             bsy,
  output logic             done,
  output logic [IDX_W:0]   word_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CAPTURE_WORDS - 1);

  state_e           state_q, state_d;
  logic [1:0]       ctrl_q;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [30:0]      sh_q, sh_d;
  logic [31:0]      pdm_q, pdm_d;
  logic             rw_q, rw_d;
  logic [IDX_W-1:0] didx_q, didx_d;
  logic [IDX_W:0]   word_cnt_q, word_cnt_d;
  logic             bsy_q, bsy_d;
  logic             done_q, done_d;

  // A command fires only on a change of the ctrl level to a non-zero code.
  logic cmd_fire, start_cmd, stop_cmd, clear_cmd, last_wr;
  assign cmd_fire  = (ctrl != ctrl_q) && (ctrl != 2'b00);
  assign start_cmd = cmd_fire && (ctrl == 2'b01);
  assign stop_cmd  = cmd_fire && (ctrl == 2'b10);
  assign clear_cmd = cmd_fire && (ctrl == 2'b11);
  assign last_wr   = rw_q && (didx_q == LAST_IDX);

  always_ff @(posedge PDMclk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (clear_cmd)      state_d = S_IDLE;
        else if (start_cmd) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (clear_cmd)                state_d = S_IDLE;
        else if (stop_cmd || last_wr) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    pdm_d      = pdm_q;
    rw_d       = 1'b0;
    didx_d     = didx_q;
    word_cnt_d = word_cnt_q;
    if (clear_cmd) begin
      bit_cnt_d  = '0;
      pdm_d      = '0;
      didx_d     = '0;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_cmd) begin
            bit_cnt_d  = '0;
            didx_d     = '0;
            word_cnt_d = '0;
          end
        end
        S_CAPT: begin
          // The strobed word is committed on the edge after RW, even if a
          // stop lands on that edge.
          if (rw_q) begin
            didx_d     = last_wr ? '0 : didx_q + 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
          end
          if (state_d == S_CAPT) begin
            sh_d      = {sh_q[29:0], pdm_signal};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              pdm_d = {sh_q, pdm_signal};
              rw_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    bsy_d  = (state_d == S_CAPT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge PDMclk) begin
    if (rst) begin
      ctrl_q     <= 2'b00;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      pdm_q      <= '0;
      rw_q       <= 1'b0;
      didx_q     <= '0;
      word_cnt_q <= '0;
      bsy_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ctrl_q     <= ctrl;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      pdm_q      <= pdm_d;
      rw_q       <= rw_d;
      didx_q     <= didx_d;
      word_cnt_q <= word_cnt_d;
      bsy_q      <= bsy_d;
      done_q     <= done_d;
    end
  end

  assign pdm      = pdm_q;
  assign RW       = rw_q;
  assign didx     = didx_q;
  assign bsy      = bsy_q;
  assign done     = done_q;
  assign word_cnt = word_cnt_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_pdm_capture_seq.sv
// Bench for pdm_capture_seq: command table plus directed capture sequences
// on a 4-word instance and a 16-word instance with a 4-bit index.
module tb_pdm_capture_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctrl1, ctrl2, ctrl_hold;
  logic        bit1, bit2;
  logic [31:0] pdm1, pdm2;
  logic        rw1, rw2, bsy1, bsy2, done1, done2;
  logic [15:0] didx1;
  logic [3:0]  didx2;
  logic [16:0] wc1;
  logic [4:0]  wc2;
  logic [1:0]  st1, st2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e0;
  logic snap_bsy, snap_rw;
  logic [31:0] pat [4];
  logic [47:0] exp_q[$];
  logic [35:0] exp2_q[$];
  int strobe_q[$];
  int strobe2_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pdm_capture_seq #(.IDX_W(16), .CAPTURE_WORDS(4)) dut1 (
    .PDMclk(clk), .rst(rst), .ctrl(ctrl1), .pdm_signal(bit1),
    .pdm(pdm1), .RW(rw1), .didx(didx1), .bsy(bsy1), .done(done1),
    .word_cnt(wc1), .state_o(st1)
  );

  pdm_capture_seq #(.IDX_W(4), .CAPTURE_WORDS(16)) dut2 (
    .PDMclk(clk), .rst(rst), .ctrl(ctrl2), .pdm_signal(bit2),
    .pdm(pdm2), .RW(rw2), .didx(didx2), .bsy(bsy2), .done(done2),
    .word_cnt(wc2), .state_o(st2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe scoreboards: every RW pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rw1 === 1'b1) begin
      logic [47:0] e;
      strobe_q.push_back(cyc);
      chk("bsy_during_rw1", bsy1, 1'b1);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe1: got didx %0h pdm %0h expected no strobe", didx1, pdm1);
      end else begin
        e = exp_q.pop_front();
        chk("strobe1_didx", didx1, e[47:32]);
        chk("strobe1_pdm", pdm1, e[31:0]);
      end
    end
    if (rw2 === 1'b1) begin
      logic [35:0] e2;
      strobe2_q.push_back(cyc);
      chk("bsy_during_rw2", bsy2, 1'b1);
      n_checks++;
      if (exp2_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe2: got didx %0h pdm %0h expected no strobe", didx2, pdm2);
      end else begin
        e2 = exp2_q.pop_front();
        chk("strobe2_didx", didx2, e2[35:32]);
        chk("strobe2_pdm", pdm2, e2[31:0]);
      end
    end
  end

  task automatic drive_cycle(input logic [1:0] c, input logic b, input bit sel);
    if (sel) begin
      ctrl2 = c; bit2 = b; ctrl1 = 2'b00; bit1 = 1'b0;
    end else begin
      ctrl1 = c; bit1 = b; ctrl2 = 2'b00; bit2 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int cpos, input logic [1:0] cval, input bit sel);
    for (int i = 0; i < 32; i++) begin
      drive_cycle((i == cpos) ? cval : ctrl_hold, w[31-i], sel);
      if (i == cpos) begin
        snap_bsy = bsy1;
        snap_rw  = rw1;
      end
    end
  endtask

  task automatic chk_grid(input string name, input int start, input int n);
    chk({name, "_count"}, strobe_q.size(), n);
    for (int k = 0; k < strobe_q.size(); k++)
      chk({name, "_time"}, strobe_q[k], start + 32 * (k + 1));
    chk({name, "_exp_left"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] ctrl;
    logic       bsy;
    logic       done;
    logic [1:0] st;
    string      name;
  } vec_t;
  vec_t tbl [15];

  initial begin
    pat[0] = 32'hA5A5_0000; pat[1] = 32'h0000_FFFF;
    pat[2] = 32'h1234_5678; pat[3] = 32'hDEAD_BEEF;
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 2'd0, "reset"};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 1'b0, 2'd0, "stop_in_idle"};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd0, "none"};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 1'b0, 2'd1, "start"};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 1'b0, 2'd1, "start_held"};
    tbl[5]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd0, "clear_capt"};
    tbl[6]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd0, "clear_held"};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 1'b0, 2'd1, "start_after_clear"};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 1'b1, 2'd2, "stop_capt"};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 1'b1, 2'd2, "stop_held"};
    tbl[10] = '{1'b0, 2'b01, 1'b1, 1'b0, 2'd1, "start_from_done"};
    tbl[11] = '{1'b1, 2'b11, 1'b0, 1'b0, 2'd0, "rst_beats_clear"};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd0, "after_rst"};
    tbl[13] = '{1'b0, 2'b10, 1'b0, 1'b0, 2'd0, "stop_in_idle2"};
    tbl[14] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd0, "idle"};

    rst = 1'b1; ctrl1 = 2'b00; ctrl2 = 2'b00; bit1 = 1'b0; bit2 = 1'b0; ctrl_hold = 2'b00;
    @(negedge clk);

    // Command table
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst;
      drive_cycle(tbl[i].ctrl, 1'b0, 1'b0);
      chk({tbl[i].name, "_bsy"}, bsy1, tbl[i].bsy);
      chk({tbl[i].name, "_done"}, done1, tbl[i].done);
      chk({tbl[i].name, "_state"}, st1, tbl[i].st);
      chk({tbl[i].name, "_rw"}, rw1, 1'b0);
      chk({tbl[i].name, "_wc"}, wc1, 0);
      chk({tbl[i].name, "_didx"}, didx1, 0);
      chk({tbl[i].name, "_pdm"}, pdm1, 0);
    end

    // Full 4-word capture
    strobe_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({16'(k), pat[k]});
    drive_cycle(2'b01, 1'b0, 1'b0);
    e0 = cyc;
    chk("a_start_bsy", bsy1, 1'b1);
    for (int k = 0; k < 4; k++) send_word(pat[k], -1, 2'b00, 1'b0);
    chk("a_last_rw", rw1, 1'b1);
    chk("a_last_didx", didx1, 3);
    chk("a_last_bsy", bsy1, 1'b1);
    chk("a_last_done", done1, 1'b0);
    drive_cycle(2'b00, 1'b0, 1'b0);
    chk("a_end_bsy", bsy1, 1'b0);
    chk("a_end_done", done1, 1'b1);
    chk("a_end_wc", wc1, 4);
    chk("a_end_didx", didx1, 0);
    chk("a_end_rw", rw1, 1'b0);
    chk("a_end_pdm", pdm1, pat[3]);
    chk("a_end_state", st1, 2'd2);
    chk_grid("a_grid", e0, 4);

    // Stop at bit 10 of word 2
    strobe_q.delete();
    for (int k = 0; k < 2; k++) exp_q.push_back({16'(k), pat[k]});
    drive_cycle(2'b01, 1'b0, 1'b0);
    e0 = cyc;
    chk("b_start_done", done1, 1'b0);
    send_word(pat[0], -1, 2'b00, 1'b0);
    send_word(pat[1], -1, 2'b00, 1'b0);
    send_word(pat[2], 10, 2'b10, 1'b0);
    chk("b_stop_bsy", snap_bsy, 1'b0);
    chk("b_stop_rw", snap_rw, 1'b0);
    for (int i = 0; i < 8; i++) drive_cycle(2'b00, 1'b1, 1'b0);
    chk("b_wc", wc1, 2);
    chk("b_done", done1, 1'b1);
    chk("b_bsy", bsy1, 1'b0);
    chk("b_pdm", pdm1, pat[1]);
    chk_grid("b_grid", e0, 2);

    // Stop on the 32nd-bit edge of word 1
    strobe_q.delete();
    exp_q.push_back({16'd0, pat[0]});
    drive_cycle(2'b01, 1'b0, 1'b0);
    e0 = cyc;
    send_word(pat[0], -1, 2'b00, 1'b0);
    send_word(pat[1], 31, 2'b10, 1'b0);
    chk("c_stop_rw", snap_rw, 1'b0);
    chk("c_stop_bsy", snap_bsy, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(2'b00, 1'b0, 1'b0);
    chk("c_wc", wc1, 1);
    chk("c_done", done1, 1'b1);
    chk("c_pdm", pdm1, pat[0]);
    chk_grid("c_grid", e0, 1);

    // Start level held for 200 cycles fires once
    strobe_q.delete();
    ctrl_hold = 2'b01;
    for (int k = 0; k < 4; k++) exp_q.push_back({16'(k), pat[k]});
    drive_cycle(2'b01, 1'b0, 1'b0);
    e0 = cyc;
    for (int k = 0; k < 4; k++) send_word(pat[k], -1, 2'b01, 1'b0);
    for (int i = 0; i < 71; i++) drive_cycle(2'b01, 1'b1, 1'b0);
    chk("d_hold_done", done1, 1'b1);
    chk("d_hold_bsy", bsy1, 1'b0);
    chk("d_hold_wc", wc1, 4);
    chk_grid("d_hold_grid", e0, 4);

    // Start again while busy is ignored
    ctrl_hold = 2'b00;
    strobe_q.delete();
    drive_cycle(2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) exp_q.push_back({16'(k), pat[3-k]});
    drive_cycle(2'b01, 1'b0, 1'b0);
    e0 = cyc;
    send_word(pat[3], -1, 2'b00, 1'b0);
    send_word(pat[2], 5, 2'b01, 1'b0);
    chk("d_restart_bsy", snap_bsy, 1'b1);
    send_word(pat[1], -1, 2'b00, 1'b0);
    send_word(pat[0], -1, 2'b00, 1'b0);
    drive_cycle(2'b00, 1'b0, 1'b0);
    chk("d_busy_wc", wc1, 4);
    chk("d_busy_done", done1, 1'b1);
    chk_grid("d_busy_grid", e0, 4);

    // Clear mid-capture, new capture, then reset mid-capture
    strobe_q.delete();
    exp_q.push_back({16'd0, pat[0]});
    drive_cycle(2'b01, 1'b0, 1'b0);
    send_word(pat[0], -1, 2'b00, 1'b0);
    send_word(pat[1], 5, 2'b11, 1'b0);
    chk("e_clear_bsy", snap_bsy, 1'b0);
    chk("e_clear_rw", snap_rw, 1'b0);
    chk("e_clear_pdm", pdm1, 0);
    chk("e_clear_didx", didx1, 0);
    chk("e_clear_wc", wc1, 0);
    chk("e_clear_done", done1, 1'b0);
    chk("e_clear_state", st1, 2'd0);
    drive_cycle(2'b00, 1'b0, 1'b0);
    exp_q.push_back({16'd0, pat[2]});
    drive_cycle(2'b01, 1'b0, 1'b0);
    send_word(pat[2], -1, 2'b00, 1'b0);
    chk("e_new_rw", rw1, 1'b1);
    chk("e_new_didx", didx1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(2'b00, pat[3][31-i], 1'b0);
    chk("e_new_wc", wc1, 1);
    rst = 1'b1;
    drive_cycle(2'b00, 1'b1, 1'b0);
    chk("e_rst_pdm", pdm1, 0);
    chk("e_rst_rw", rw1, 1'b0);
    chk("e_rst_didx", didx1, 0);
    chk("e_rst_bsy", bsy1, 1'b0);
    chk("e_rst_done", done1, 1'b0);
    chk("e_rst_wc", wc1, 0);
    chk("e_rst_state", st1, 2'd0);
    rst = 1'b0;
    drive_cycle(2'b00, 1'b0, 1'b0);
    chk("e_exp_left", exp_q.size(), 0);

    // Full index range on the 4-bit instance
    strobe2_q.delete();
    for (int k = 0; k < 16; k++) exp2_q.push_back({4'(k), pat[k % 4] + 32'(k)});
    drive_cycle(2'b01, 1'b0, 1'b1);
    e0 = cyc;
    for (int k = 0; k < 16; k++) send_word(pat[k % 4] + 32'(k), -1, 2'b00, 1'b1);
    chk("f_last_rw", rw2, 1'b1);
    chk("f_last_didx", didx2, 15);
    chk("f_last_bsy", bsy2, 1'b1);
    drive_cycle(2'b00, 1'b0, 1'b1);
    chk("f_end_didx", didx2, 0);
    chk("f_end_wc", wc2, 16);
    chk("f_end_done", done2, 1'b1);
    chk("f_end_bsy", bsy2, 1'b0);
    chk("f_end_rw", rw2, 1'b0);
    chk("f_strobe_count", strobe2_q.size(), 16);
    if (strobe2_q.size() == 16) begin
      chk("f_first_time", strobe2_q[0], e0 + 32);
      chk("f_last_time", strobe2_q[15], e0 + 512);
    end
    chk("f_exp_left", exp2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
